cpu_mem_arbiter: RTL

- Sits directly downstream of the pipelined CPU top level, between its instruction-fetch port and data-memory port and one single-ported unified memory.
- Serialises instruction reads and data reads/writes onto that memory.
- Supports variable memory latency through a ready handshake.
- Returns per-port valid pulses and stall levels that the fetch and memory stages use to freeze the pipeline.

---
 rtl/cpu_mem_arbiter_pkg.sv | 15 +
 rtl/cpu_mem_arbiter_priority_sel.sv | 31 +++
 rtl/cpu_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and widths for the CPU memory arbiter. The CPU top level
// uses the same width defaults.
package cpu_mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int BURST_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter_priority_sel.sv
// Combinational grant decision: data first, unless a waiting fetch has
// already been passed over MAX_D_BURST times in a row.
module arb_priority_sel
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic                   rd_instr_en,
    input  logic                   instr_valid,
    input  logic                   rd_data_en,
    input  logic                   wr_data_en,
    input  logic                   data_valid,
    input  logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   grant_i,
    output logic                   grant_d
);

    logic req_i;
    logic req_d;
    logic starved;

    // A port is masked in its valid cycle so a held request is not re-issued.
    always_comb begin
        req_i   = rd_instr_en & ~instr_valid;
        req_d   = (rd_data_en | wr_data_en) & ~data_valid;
        starved = req_i && (burst_cnt == BURST_CNT_W'(MAX_D_BURST));
        grant_d = req_d & ~starved;
        grant_i = req_i & ~grant_d;
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one
// single-ported memory with a ready handshake.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              rd_instr_en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              rd_data_en,
    input  logic              wr_data_en,
    input  logic [DATA_W-1:0] wrt_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              instr_stall,
    output logic              data_stall,
    output logic              data_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t             state_reg;
    arb_state_t             state_next;
    logic [BURST_CNT_W-1:0] burst_cnt_reg;
    logic [DATA_W-1:0]      instr_reg;
    logic [DATA_W-1:0]      data_reg;
    logic                   instr_valid_reg;
    logic                   data_valid_reg;
    logic                   data_err_reg;
    logic [ADDR_W-1:0]      mem_addr_reg;
    logic                   mem_rd_reg;
    logic                   mem_wr_reg;
    logic [DATA_W-1:0]      mem_wdata_reg;

    logic grant_i;
    logic grant_d;
    logic issue_i;
    logic issue_d;
    logic complete_i;
    logic complete_d;

    arb_priority_sel #(
        .MAX_D_BURST (MAX_D_BURST)
    ) u_sel (
        .rd_instr_en (rd_instr_en),
        .instr_valid (instr_valid_reg),
        .rd_data_en  (rd_data_en),
        .wr_data_en  (wr_data_en),
        .data_valid  (data_valid_reg),
        .burst_cnt   (burst_cnt_reg),
        .grant_i     (grant_i),
        .grant_d     (grant_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: if (mem_ready) state_next = IDLE;
            SERVE_D: if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue_d     = (state_reg == IDLE) && grant_d;
        issue_i     = (state_reg == IDLE) && grant_i;
        complete_i  = (state_reg == SERVE_I) && mem_ready;
        complete_d  = (state_reg == SERVE_D) && mem_ready;
        instr_stall = rd_instr_en & ~instr_valid_reg;
        data_stall  = (rd_data_en | wr_data_en) & ~data_valid_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_cnt_reg   <= '0;
            instr_reg       <= '0;
            data_reg        <= '0;
            instr_valid_reg <= 1'b0;
            data_valid_reg  <= 1'b0;
            data_err_reg    <= 1'b0;
            mem_addr_reg    <= '0;
            mem_rd_reg      <= 1'b0;
            mem_wr_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
        end else begin
            instr_valid_reg <= complete_i;
            data_valid_reg  <= complete_d;
            // Conflicting load+store is executed as a store and flagged alongside its strobe.
            data_err_reg    <= issue_d & rd_data_en & wr_data_en;

            if (issue_d) begin
                mem_addr_reg  <= data_addr;
                mem_wr_reg    <= wr_data_en;
                mem_rd_reg    <= ~wr_data_en;
                mem_wdata_reg <= wr_data_en ? wrt_data : '0;
                if (!rd_instr_en) begin
                    burst_cnt_reg <= '0;
                end else if (burst_cnt_reg != BURST_CNT_W'(MAX_D_BURST)) begin
                    burst_cnt_reg <= burst_cnt_reg + 1'b1;
                end
            end else if (issue_i) begin
                mem_addr_reg  <= instr_addr;
                mem_rd_reg    <= 1'b1;
                mem_wr_reg    <= 1'b0;
                mem_wdata_reg <= '0;
                burst_cnt_reg <= '0;
            end

            if (complete_i) begin
                mem_rd_reg <= 1'b0;
                instr_reg  <= mem_rdata;
            end
            if (complete_d) begin
                mem_rd_reg <= 1'b0;
                mem_wr_reg <= 1'b0;
                if (mem_rd_reg) begin
                    data_reg <= mem_rdata;
                end
            end
        end
    end

    assign instr       = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign data        = data_reg;
    assign data_valid  = data_valid_reg;
    assign data_err    = data_err_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_rd      = mem_rd_reg;
    assign mem_wr      = mem_wr_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule
